// File: rtl/poly_arith_pkg.sv
// Purpose: shared ML-KEM coefficient arithmetic types and constants (Q = 3329).
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package poly_arith_pkg;

    typedef logic [11:0] coeff_t;   // one coefficient, canonical range 0..Q-1
    typedef logic [12:0] diff_t;    // two's-complement difference of two coeff_t

    localparam coeff_t Q               = 12'd3329;
    localparam int     N_COEFF_DEFAULT = 256;

    // Zero-extend both operands so bit 12 of the result is the borrow/sign.
    function automatic diff_t sub_raw(input coeff_t a, input coeff_t b);
        return {1'b0, a} - {1'b0, b};
    endfunction

endpackage

// File: rtl/poly_sub_stream_if.sv
// Purpose: stream bundle for poly_sub_stream (input beat, output beat, status).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; slave = subtractor, master = its driver.
// Signals: valid_i/ready_o/op1_i/op2_i (input beat), valid_o/ready_i/result_o/last_o
//          (output beat), poly_done_o and range_err_o (status).
interface poly_sub_stream_if;
    import poly_arith_pkg::*;

    logic   valid_i;
    logic   ready_o;
    coeff_t op1_i;
    coeff_t op2_i;
    logic   valid_o;
    logic   ready_i;
    coeff_t result_o;
    logic   last_o;
    logic   poly_done_o;
    logic   range_err_o;

    modport slave (
        input  valid_i, op1_i, op2_i, ready_i,
        output ready_o, valid_o, result_o, last_o, poly_done_o, range_err_o
    );

    modport master (
        output valid_i, op1_i, op2_i, ready_i,
        input  ready_o, valid_o, result_o, last_o, poly_done_o, range_err_o
    );

endinterface

// File: rtl/mod_sub_reduce.sv
// Purpose: fold a 13-bit signed difference back into 0..Q-1 with one conditional +Q.
// Latency: combinational.
// Backpressure: none (pure function).
// Ports: diff (diff_t, sign in bit 12) in, result (coeff_t) out.
module mod_sub_reduce
    import poly_arith_pkg::*;
(
    input  diff_t  diff,
    output coeff_t result
);

    // A negative difference lies in -(Q-1)..-1, so adding Q once and keeping
    // 12 bits lands it in 1..Q-1. Non-negative values are already reduced.
    always_comb begin
        result = diff[11:0];
        if (diff[12]) begin
            result = diff[11:0] + Q;
        end
    end

endmodule

// File: rtl/poly_sub_stream.sv
// Purpose: streaming (op1 - op2) mod Q per coefficient, tagging the last beat of each polynomial.
// Latency: 2 cycles accept-to-valid_o when unstalled; 1 beat/cycle throughput.
// Backpressure: 2-stage pipe with per-stage advance; ready_o drops only when both stages hold data and ready_i is low.
// Ports: clk, rst (synchronous, active low), bus (poly_sub_stream_if.slave).
// Build option: POLY_SUB_RANGE_CHECK_EN enables the sticky out-of-range flag on range_err_o.
module poly_sub_stream
    import poly_arith_pkg::*;
#(
    parameter int N_COEFF = N_COEFF_DEFAULT,     // power of two
    parameter int IDX_W   = $clog2(N_COEFF)
) (
    input  logic                clk,
    input  logic                rst,
    poly_sub_stream_if.slave    bus
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COEFF - 1);

    logic             adv1;
    logic             adv2;
    logic             accept;

    logic [IDX_W-1:0] idx;

    logic             s1_valid;
    logic             s1_last;
    diff_t            s1_diff;

    logic             s2_valid;
    logic             s2_last;
    coeff_t           s2_result;
    coeff_t           reduced;

    logic             poly_done;

    // Each stage moves when its successor is empty or draining this cycle,
    // which lets a consume and a new accept share one cycle without a bubble.
    assign adv2   = !s2_valid || bus.ready_i;
    assign adv1   = !s1_valid || adv2;
    assign accept = bus.valid_i && adv1;

    // Coefficient index; wraps naturally because N_COEFF is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx <= '0;
        end else if (accept) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Stage 1: raw difference and last-beat tag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_diff  <= '0;
        end else if (adv1) begin
            s1_valid <= bus.valid_i;
            if (bus.valid_i) begin
                s1_diff <= sub_raw(bus.op1_i, bus.op2_i);
                s1_last <= (idx == IDX_LAST);
            end
        end
    end

    mod_sub_reduce u_reduce (
        .diff   (s1_diff),
        .result (reduced)
    );

    // Stage 2: reduced result. last is qualified with valid so it never
    // lingers on an empty output slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_result <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                s2_result <= reduced;
            end
        end
    end

    // Pulse the cycle after the last beat of a polynomial leaves.
    always_ff @(posedge clk) begin
        if (!rst) begin
            poly_done <= 1'b0;
        end else begin
            poly_done <= s2_valid && s2_last && bus.ready_i;
        end
    end

`ifdef POLY_SUB_RANGE_CHECK_EN
    logic range_err;

    // Sticky until reset; the datapath still processes the raw operands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            range_err <= 1'b0;
        end else if (accept && ((bus.op1_i >= Q) || (bus.op2_i >= Q))) begin
            range_err <= 1'b1;
        end
    end

    assign bus.range_err_o = range_err;
`else
    assign bus.range_err_o = 1'b0;
`endif

    assign bus.ready_o     = adv1;
    assign bus.valid_o     = s2_valid;
    assign bus.result_o    = s2_result;
    assign bus.last_o      = s2_last;
    assign bus.poly_done_o = poly_done;

endmodule

// File: tb/tb_poly_sub_stream.sv
// Purpose: self-checking bench for poly_sub_stream against a queue-based reference model.
// Latency: checks 2-cycle accept-to-output latency in unstalled phases.
// Backpressure: exercises ready_i stalls and checks ready_o against model occupancy.
module tb_poly_sub_stream;
    import poly_arith_pkg::*;

    localparam int N = 256;

    logic clk;
    logic rst;

    poly_sub_stream_if bus ();

    poly_sub_stream #(.N_COEFF(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int res;
        bit last;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   tests      = 0;
    int   fails      = 0;
    int   cyc        = 0;
    int   n_acc      = 0;      // accepted beats since reset
    int   n_done     = 0;      // observed poly_done_o pulses
    int   run        = 0;
    int   max_run    = 0;
    bit   pend_done  = 0;
    bit   exp_rerr   = 0;
    bit   strict_lat = 0;
    bit   saw_rdy_lo = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Spec-level reference: canonical modular subtraction for in-range
    // operands; for out-of-range operands, the raw conditional +Q rule.
    function automatic int ref_sub(input int a, input int b);
        int d;
        if (a < int'(Q) && b < int'(Q)) return (a - b + int'(Q)) % int'(Q);
        d = a - b;
        if (d < 0) return (d + 8192 + int'(Q)) % 4096;
        return d % 4096;
    endfunction

    // One clock cycle: check outputs against the model, log handshakes,
    // then advance to the next falling edge where the caller drives inputs.
    task automatic tick(output bit acc);
        bit exp_vld;
        exp_t e;
        #1;
        acc = 0;
        if (!rst) begin
            q.delete();
            n_acc     = 0;
            pend_done = 0;
            exp_rerr  = 0;
            run       = 0;
        end else begin
            exp_vld = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
            chk("valid_o", bus.valid_o, exp_vld);
            chk("ready_o", bus.ready_o, (q.size() < 2) || bus.ready_i);
            chk("poly_done_o", bus.poly_done_o, pend_done);
            chk("range_err_o", bus.range_err_o, exp_rerr);
            if (bus.poly_done_o) n_done++;
            if (!bus.ready_o) saw_rdy_lo = 1;
            if (bus.valid_o) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            pend_done = 0;
            if (bus.valid_o && q.size() > 0) begin
                // Checked every valid cycle, so a stalled beat must stay put.
                chk("result_o", bus.result_o, q[0].res[15:0]);
                chk("last_o", bus.last_o, q[0].last);
                if (bus.ready_i) begin
                    e = q.pop_front();
                    if (strict_lat) chk("latency", cyc - e.cyc, 2);
                    pend_done = e.last;
                end
            end
            if (bus.valid_i && bus.ready_o) begin
                acc = 1;
                e.res  = ref_sub(int'(bus.op1_i), int'(bus.op2_i));
                e.last = ((n_acc % N) == N - 1);
                e.cyc  = cyc;
                q.push_back(e);
                n_acc++;
`ifdef POLY_SUB_RANGE_CHECK_EN
                if (bus.op1_i >= Q || bus.op2_i >= Q) exp_rerr = 1;
`endif
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input int a, input int b);
        bit acc;
        acc = 0;
        bus.valid_i = 1'b1;
        bus.op1_i   = coeff_t'(a);
        bus.op2_i   = coeff_t'(b);
        for (int t = 0; t < 50 && !acc; t++) tick(acc);
        chk("send_accept", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        bus.valid_i = 1'b0;
        for (int t = 0; t < 64 && q.size() > 0; t++) tick(acc);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        bit acc;
        rst         = 1'b0;
        bus.valid_i = 1'b0;
        tick(acc);
        rst = 1'b1;
        #1;
        chk("rst_valid_o", bus.valid_o, 0);
        chk("rst_last_o", bus.last_o, 0);
        chk("rst_poly_done_o", bus.poly_done_o, 0);
        chk("rst_range_err_o", bus.range_err_o, 0);
        chk("rst_result_o", bus.result_o, 0);
        chk("rst_ready_o", bus.ready_o, 1);
    endtask

    initial begin
        int bp_sent;
        int done0;
        bit acc;

        rst         = 1'b0;
        bus.valid_i = 1'b0;
        bus.op1_i   = '0;
        bus.op2_i   = '0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        do_reset();

        // Directed values, back to back with ready_i high.
        strict_lat = 1;
        max_run    = 0;
        send(20, 10);
        send(10, 20);
        send(0, 3328);
        send(3328, 0);
        drain();
        chk("directed_valid_run", max_run, 4);

        // Zero and equal operands.
        send(0, 0);
        send(1234, 1234);
        drain();

        // Backpressure: ready_i low for 4 cycles starting at the 2nd output.
        strict_lat = 0;
        saw_rdy_lo = 0;
        bp_sent    = 0;
        for (int k = 0; k < 30; k++) begin
            bus.ready_i = !(k >= 3 && k <= 6);
            bus.valid_i = (bp_sent < 5);
            bus.op1_i   = coeff_t'($urandom_range(0, 3328));
            bus.op2_i   = coeff_t'($urandom_range(0, 3328));
            tick(acc);
            if (acc) bp_sent++;
        end
        bus.ready_i = 1'b1;
        chk("bp_sent", bp_sent, 5);
        chk("bp_ready_dropped", saw_rdy_lo, 1);
        drain();

        // Two full polynomials of random coefficients.
        do_reset();
        strict_lat = 1;
        done0      = n_done;
        for (int i = 0; i < 2 * N; i++) send($urandom_range(0, 3328), $urandom_range(0, 3328));
        drain();
        bus.valid_i = 1'b0;
        tick(acc);
        chk("poly_done_count", n_done - done0, 2);

        // Reset mid-stream at beat 100, then one full polynomial.
        for (int i = 0; i < 100; i++) send($urandom_range(0, 3328), $urandom_range(0, 3328));
        do_reset();
        done0 = n_done;
        for (int i = 0; i < N; i++) send($urandom_range(0, 3328), $urandom_range(0, 3328));
        drain();
        tick(acc);
        chk("post_reset_done_count", n_done - done0, 1);

        // Out-of-range operand; flag behaviour depends on the build option.
        send(3329, 0);
        for (int i = 0; i < 4; i++) send($urandom_range(0, 3328), $urandom_range(0, 3328));
        drain();
        for (int i = 0; i < 3; i++) tick(acc);
`ifdef POLY_SUB_RANGE_CHECK_EN
        chk("range_err_sticky", bus.range_err_o, 1);
`else
        chk("range_err_tied", bus.range_err_o, 0);
`endif
        do_reset();
        tick(acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/poly_sub_stream.md
Name: poly_sub_stream

Overview:
- Streaming modular subtractor for ML-KEM (FIPS 203) polynomials. Computes (op1 - op2) mod Q, with Q = 3329, one coefficient pair per beat.
- Interfaces use valid/ready handshakes with full backpressure. The datapath is a 2-stage pipeline.
- Counts coefficients per polynomial and tags the last output beat of each polynomial.
- Used for ciphertext/message recovery (v - s^T u) and NTT-domain subtraction. It is the inverse-direction companion of the combinational modular adder.

Parameters:
- N_COEFF, 256, coefficients per polynomial; must be a power of 2.
- IDX_W, $clog2(N_COEFF), width of the coefficient index counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept an input beat.
- op1_i  in  12 (coeff_t)  minuend, expected range 0..Q-1.
- op2_i  in  12 (coeff_t)  subtrahend, expected range 0..Q-1.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the output beat.
- result_o  out  12 (coeff_t)  (op1 - op2) mod Q.
- last_o  out  1  high with the output beat of coefficient index N_COEFF-1.
- poly_done_o  out  1  one-cycle pulse when a last_o beat completes its handshake.
- range_err_o  out  1  sticky flag for out-of-range inputs; only active with the optional feature.

Behaviour:
- Reset (rst == 0 at a clk edge) forces the following to 0:
  - valid_o, last_o, poly_done_o, range_err_o
  - both stage valid bits
  - the coefficient index counter
- result_o also resets to 0. ready_o is 1 in the first cycle after reset.
- A reset mid-polynomial discards in-flight beats and restarts indexing at 0.
- Handshakes:
  - An input is accepted when valid_i && ready_o.
  - An output is consumed when valid_o && ready_i.
  - valid_o, result_o and last_o hold stable while valid_o && !ready_i.
- Stage advance rules:
  - adv2 = !s2_valid || ready_i.
  - adv1 = !s1_valid || adv2.
  - ready_o = adv1. The signal is combinational and has no dependency on valid_i.
- Stage 1 computes diff = {1'b0,op1} - {1'b0,op2} as a 13-bit two's-complement value and registers diff, s1_valid and s1_last.
- Stage 2 computes the result:
  - if diff[12] == 1, result = diff[11:0] + Q, truncated to 12 bits;
  - otherwise result = diff[11:0].
  - The result is registered into result_o.
- Latency and throughput:
  - Latency is 2 cycles from input accept to valid_o, when not stalled.
  - Throughput is 1 beat per cycle when ready_i is held at 1.
  - Occupancy is at most 2 beats. With ready_i low, ready_o goes low once both stages are full.
- Index counter:
  - Increments on each input accept and wraps from N_COEFF-1 to 0.
  - s1_last = (idx == N_COEFF-1), sampled at accept and carried through the pipe.
- poly_done_o is asserted the cycle after the last-beat output handshake, for exactly 1 cycle.
- Simultaneous output consume and new input accept in the same cycle is legal and required: no bubble is inserted.
- Inputs at or above Q are not corrected. The result is stage-2 arithmetic applied to the raw inputs (defined but meaningless).

Optional Feature:
- Macro: POLY_SUB_RANGE_CHECK_EN.
- Defined:
  - On accept, if op1_i >= Q or op2_i >= Q, range_err_o is set to 1.
  - It stays 1 until reset; the datapath is unaffected.
- Undefined: range_err_o is tied to 0 and no comparators are synthesised.

Decomposition:
- poly_arith_pkg holds:
  - Q (3329) and coeff_t (logic [11:0]);
  - a new diff_t (logic [12:0]);
  - a new N_COEFF default constant.
- One natural sub-module, mod_sub_reduce: combinational, diff_t in, coeff_t out (conditional +Q). Stage 2 instantiates it; it can later be shared with butterfly units.

Test Plan:
- Directed values with ready_i = 1 -> results after 2 cycles, in order, with valid_o high for 4 consecutive cycles:
  - 20 - 10 -> 10
  - 10 - 20 -> 3319
  - 0 - 3328 -> 1
  - 3328 - 0 -> 3328
- Zero and equal operands: 0 - 0 -> 0 and 1234 - 1234 -> 0. No reduction path taken.
- Backpressure:
  - Stream 5 beats with ready_i low for 4 cycles starting at the 2nd output.
  - ready_o drops once 2 beats are held; result_o stays stable.
  - All 5 results arrive in order with no loss or duplication.
- Full polynomial:
  - Send 256 random beats, then 256 more.
  - last_o is high only on output beats 255 and 511.
  - poly_done_o pulses exactly twice, one cycle after each last handshake.
  - All results match ((a - b + Q) % Q).
- Reset mid-stream:
  - Assert rst low at beat 100 for 1 cycle.
  - valid_o = 0 next cycle, and no stale output appears afterwards.
  - The next 256 beats place last_o on the 256th post-reset beat.
- With POLY_SUB_RANGE_CHECK_EN:
  - op1 = 3329, op2 = 0 sets range_err_o = 1, and it stays set until reset.
  - Without the macro, the same stimulus leaves range_err_o = 0.
